// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer
//   Upstream feeder for the bit-serial adder datapath. Accepts a parallel
//   operand pair (a_in, b_in) and streams it out LSB first, one bit per
//   transfer, flagging the first and last bit of each word. Back-to-back
//   words run without a bubble: the next pair loads on the last transfer.
//
//   Optional feature (macro SERIALIZER_CIN_EN): adds cin_in, captured with
//   the operands, and cin_bit, which presents that carry-in on bit 0 only.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. A producer holding valid keeps its data stable until that
//   edge. in_ready may depend combinationally on bit_ready (the no-bubble
//   reload on the last bit), but never on in_valid.

module serial_operand_serializer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             a_bit,
  output logic             b_bit,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy,
  output logic             dbg_state
`ifdef SERIALIZER_CIN_EN
  ,
  input  logic             cin_in,
  output logic             cin_bit
`endif
);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_operand_serializer: WIDTH must be in 2..32");
    end
  endgenerate

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             load;
  logic             last_xfer;

  // Output decode straight from the registers; in_ready opens on the last transfer.
  assign bit_valid = (state == SHIFT);
  assign busy      = bit_valid;
  assign dbg_state = state;
  assign a_bit     = a_sh[0];
  assign b_bit     = b_sh[0];
  assign first_bit = bit_valid && (cnt == '0);
  assign last_bit  = bit_valid && (cnt == CNT_LAST);
  assign last_xfer = last_bit && bit_ready;
  assign in_ready  = rst_n && ((state == IDLE) || last_xfer);
  assign load      = in_valid && in_ready;

  // Load / shift / retire state machine; a stall (bit_ready low) holds everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else if (load) begin
      state <= SHIFT;
      cnt   <= '0;
      a_sh  <= a_in;
      b_sh  <= b_in;
    end else if (bit_valid && bit_ready) begin
      if (last_bit) begin
        state <= IDLE;
        cnt   <= '0;
        a_sh  <= '0;
        b_sh  <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
        a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      end
    end
  end

`ifdef SERIALIZER_CIN_EN
  logic cin_r;

  // Carry-in travels with the word and is cleared once the word retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cin_r <= 1'b0;
    end else if (load) begin
      cin_r <= cin_in;
    end else if (last_xfer) begin
      cin_r <= 1'b0;
    end
  end

  assign cin_bit = first_bit ? cin_r : 1'b0;
`endif

endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb_serial_operand_serializer
//   Directed bench for serial_operand_serializer (WIDTH=3): a cycle table for
//   reset exit, a single word and back-to-back words, then hand sequences for
//   stall, busy rejection, reset mid-word and (with SERIALIZER_CIN_EN) carry-in.

module tb_serial_operand_serializer;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bit_valid;
  logic         bit_ready;
  logic         a_bit;
  logic         b_bit;
  logic         first_bit;
  logic         last_bit;
  logic         busy;
  logic         dbg_state;
`ifdef SERIALIZER_CIN_EN
  logic         cin_in;
  logic         cin_bit;
`endif

  int checks;
  int failures;
  int first_seen;
  int last_seen;

  // Expected transfers: {first, last, a, b}
  logic [3:0] exp_q[$];

  typedef struct {
    logic         vld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rdy;
    logic         e_bv;
    logic         e_a;
    logic         e_b;
    logic         e_f;
    logic         e_l;
    logic         e_ir;
  } vec_t;

  vec_t tbl[13];

  serial_operand_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .first_bit (first_bit),
    .last_bit  (last_bit),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef SERIALIZER_CIN_EN
    ,
    .cin_in    (cin_in),
    .cin_bit   (cin_bit)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic vld, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic rdy, input logic bv,
                         input logic ab, input logic bb, input logic f,
                         input logic l, input logic ir);
    tbl[i].vld = vld; tbl[i].a = a; tbl[i].b = b; tbl[i].rdy = rdy;
    tbl[i].e_bv = bv; tbl[i].e_a = ab; tbl[i].e_b = bb;
    tbl[i].e_f = f; tbl[i].e_l = l; tbl[i].e_ir = ir;
  endtask

  task automatic drive(input logic vld, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rdy);
    in_valid  = vld;
    a_in      = a;
    b_in      = b;
    bit_ready = rdy;
  endtask

  task automatic push_word(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < W; i++)
      exp_q.push_back({(i == 0), (i == W - 1), a[i], b[i]});
  endtask

  // One clock cycle: check in_ready, compare the presented bit with the
  // scoreboard head (popping it if consumed), then step past the next edge.
  task automatic cyc(input logic exp_rdy, input string nm);
    logic [3:0] obs;
    logic [3:0] head;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, exp_rdy);
    if (first_bit) first_seen++;
    if (last_bit) last_seen++;
    if (bit_valid) begin
      obs = {first_bit, last_bit, a_bit, b_bit};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_unexpected_bit actual=%0h expected=none", nm, obs);
      end else begin
        chk({nm, "_bit"}, obs, exp_q[0]);
        if (bit_ready) head = exp_q.pop_front();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    first_seen = 0;
    last_seen  = 0;
`ifdef SERIALIZER_CIN_EN
    cin_in = 1'b0;
`endif

    // Reset; in_valid high during reset must not be accepted
    rst_n = 1'b0;
    drive(1'b1, 3'b111, 3'b111, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_bit_valid", bit_valid, 1'b0);
    chk("reset_busy",      busy,      1'b0);
    chk("reset_first",     first_bit, 1'b0);
    chk("reset_last",      last_bit,  1'b0);
    chk("reset_a_bit",     a_bit,     1'b0);
    chk("reset_b_bit",     b_bit,     1'b0);
    chk("reset_in_ready",  in_ready,  1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 3'b000, 3'b000, 1'b1);

    // Single word 011/101, then back-to-back 111/111 and 010/100
    //          i  vld  a       b       rdy  bv  a  b  f  l  ir
    set_row( 0, 1, 3'b011, 3'b101, 1,  0, 0, 0, 0, 0, 1);
    set_row( 1, 0, 3'b000, 3'b000, 1,  1, 1, 1, 1, 0, 0);
    set_row( 2, 0, 3'b000, 3'b000, 1,  1, 1, 0, 0, 0, 0);
    set_row( 3, 0, 3'b000, 3'b000, 1,  1, 0, 1, 0, 1, 1);
    set_row( 4, 0, 3'b000, 3'b000, 1,  0, 0, 0, 0, 0, 1);
    set_row( 5, 1, 3'b111, 3'b111, 1,  0, 0, 0, 0, 0, 1);
    set_row( 6, 1, 3'b010, 3'b100, 1,  1, 1, 1, 1, 0, 0);
    set_row( 7, 1, 3'b010, 3'b100, 1,  1, 1, 1, 0, 0, 0);
    set_row( 8, 1, 3'b010, 3'b100, 1,  1, 1, 1, 0, 1, 1);
    set_row( 9, 0, 3'b000, 3'b000, 1,  1, 0, 0, 1, 0, 0);
    set_row(10, 0, 3'b000, 3'b000, 1,  1, 1, 0, 0, 0, 0);
    set_row(11, 0, 3'b000, 3'b000, 1,  1, 0, 1, 0, 1, 1);
    set_row(12, 0, 3'b000, 3'b000, 1,  0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_bit_valid", i), bit_valid, tbl[i].e_bv);
      chk($sformatf("vec%0d_busy", i),      busy,      tbl[i].e_bv);
      chk($sformatf("vec%0d_a_bit", i),     a_bit,     tbl[i].e_a);
      chk($sformatf("vec%0d_b_bit", i),     b_bit,     tbl[i].e_b);
      chk($sformatf("vec%0d_first", i),     first_bit, tbl[i].e_f);
      chk($sformatf("vec%0d_last", i),      last_bit,  tbl[i].e_l);
      chk($sformatf("vec%0d_in_ready", i),  in_ready,  tbl[i].e_ir);
      @(posedge clk);
      #1;
    end

    // Downstream stall: bit 0 held three cycles
    first_seen = 0;
    last_seen  = 0;
    drive(1'b1, 3'b001, 3'b001, 1'b1);
    push_word(3'b001, 3'b001);
    cyc(1'b1, "stall_load");
    drive(1'b0, 3'b000, 3'b000, 1'b0);
    cyc(1'b0, "stall_hold0");
    cyc(1'b0, "stall_hold1");
    bit_ready = 1'b1;
    cyc(1'b0, "stall_bit0");
    cyc(1'b0, "stall_bit1");
    cyc(1'b1, "stall_bit2");
    cyc(1'b1, "stall_idle");
    chk("stall_first_cycles", first_seen, 3);
    chk("stall_last_cycles",  last_seen,  1);
    chk("stall_queue_empty",  exp_q.size(), 0);

    // Busy rejection: 110 offered during bit 1, accepted on the last transfer
    drive(1'b1, 3'b101, 3'b011, 1'b1);
    push_word(3'b101, 3'b011);
    cyc(1'b1, "busy_load");
    drive(1'b0, 3'b000, 3'b000, 1'b1);
    cyc(1'b0, "busy_bit0");
    drive(1'b1, 3'b110, 3'b010, 1'b1);
    cyc(1'b0, "busy_reject");
    push_word(3'b110, 3'b010);
    cyc(1'b1, "busy_accept");
    drive(1'b0, 3'b000, 3'b000, 1'b1);
    cyc(1'b0, "busy_w2_bit0");
    cyc(1'b0, "busy_w2_bit1");
    cyc(1'b1, "busy_w2_bit2");
    cyc(1'b1, "busy_idle");
    chk("busy_queue_empty", exp_q.size(), 0);

    // Reset mid-word at bit 1 of 011, then a clean 001/001 word
    drive(1'b1, 3'b011, 3'b000, 1'b1);
    push_word(3'b011, 3'b000);
    cyc(1'b1, "rst_load");
    drive(1'b0, 3'b000, 3'b000, 1'b1);
    cyc(1'b0, "rst_bit0");
    last_seen = 0;
    rst_n = 1'b0;
    cyc(1'b0, "rst_bit1");
    exp_q.delete();
    rst_n = 1'b1;
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_last",      last_bit,  1'b0);
    drive(1'b1, 3'b001, 3'b001, 1'b1);
    push_word(3'b001, 3'b001);
    cyc(1'b1, "rst_reload");
    chk("rst_no_partial_last", last_seen, 0);
    drive(1'b0, 3'b000, 3'b000, 1'b1);
    cyc(1'b0, "rst_w2_bit0");
    cyc(1'b0, "rst_w2_bit1");
    cyc(1'b1, "rst_w2_bit2");
    cyc(1'b1, "rst_idle");
    chk("rst_queue_empty", exp_q.size(), 0);

`ifdef SERIALIZER_CIN_EN
    // Carry-in presented on bit 0 only
    drive(1'b1, 3'b111, 3'b000, 1'b1);
    cin_in = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 3'b000, 3'b000, 1'b1);
    cin_in = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk($sformatf("cin_bit%0d", i),   cin_bit,   (i == 0));
      chk($sformatf("cin_first%0d", i), first_bit, (i == 0));
      chk($sformatf("cin_a%0d", i),     a_bit,     1'b1);
      @(posedge clk);
      #1;
    end
    chk("cin_idle", cin_bit, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
